// File: rtl/keccak_pkg.sv
// Shared Keccak definitions: hash mode enumerants, digest sizes and the squeeze FSM state type.
package keccak_pkg;

    localparam int MODE_SEL_WIDTH = 3;
    localparam int RATE_WIDTH     = 11;
    localparam int STATE_WIDTH    = 1600;

    typedef enum logic [MODE_SEL_WIDTH-1:0] {
        SHA3_224 = 3'd0,
        SHA3_256 = 3'd1,
        SHA3_384 = 3'd2,
        SHA3_512 = 3'd3,
        SHAKE128 = 3'd4,
        SHAKE256 = 3'd5
    } keccak_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        PERM_WAIT,
        DONE
    } squeeze_state_e;

    // Fixed-length modes only; SHAKE lengths come from the caller.
    function automatic logic [7:0] digest_bytes(keccak_mode_e mode);
        case (mode)
            SHA3_224: return 8'd28;
            SHA3_256: return 8'd32;
            SHA3_384: return 8'd48;
            SHA3_512: return 8'd64;
            default:  return 8'd0;
        endcase
    endfunction

    function automatic logic is_shake(keccak_mode_e mode);
        return (mode == SHAKE128) || (mode == SHAKE256);
    endfunction

endpackage

// File: rtl/squeeze_window.sv
// Combinational beat extraction: a byte-aligned window of the linear state and its tkeep mask.
module squeeze_window
    import keccak_pkg::*;
#(
    parameter int OUT_DWIDTH = 256,
    parameter int LEN_WIDTH  = 16
) (
    input  logic [STATE_WIDTH-1:0]  state_lin,
    input  logic [LEN_WIDTH-1:0]    offset,
    input  logic [LEN_WIDTH-1:0]    n_bytes,
    output logic [OUT_DWIDTH-1:0]   data,
    output logic [OUT_DWIDTH/8-1:0] keep
);

    localparam int KB = OUT_DWIDTH / 8;

    // Zero padding keeps a window near the top of the state from reading past it.
    always_comb begin
        data = OUT_DWIDTH'({{OUT_DWIDTH{1'b0}}, state_lin} >> {offset, 3'b000});
        keep = '0;
        for (int i = 0; i < KB; i++) begin
            keep[i] = (LEN_WIDTH'(i) < n_bytes);
        end
    end

endmodule

// File: rtl/squeeze_engine.sv
// Keccak squeeze engine: streams rate-sized state slices over AXI-Stream, requesting permutations between blocks.
// Optional feature: define SQUEEZE_ABORT_EN to add the abort_i input.
module squeeze_engine
    import keccak_pkg::*;
#(
    parameter int OUT_DWIDTH = 256,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
    input  logic [RATE_WIDTH-1:0]     rate_i,
    input  logic [LEN_WIDTH-1:0]      out_len_i,
    input  logic [4:0][4:0][63:0]     state_array_i,
    output logic                      perm_req_o,
    input  logic                      perm_done_i,
`ifdef SQUEEZE_ABORT_EN
    input  logic                      abort_i,
`endif
    output logic [OUT_DWIDTH-1:0]     m_axis_tdata_o,
    output logic [OUT_DWIDTH/8-1:0]   m_axis_tkeep_o,
    output logic                      m_axis_tlast_o,
    output logic                      m_axis_tvalid_o,
    input  logic                      m_axis_tready_i,
    output logic                      busy_o
);

    localparam logic [LEN_WIDTH-1:0] KB = LEN_WIDTH'(OUT_DWIDTH / 8);

    squeeze_state_e         state;
    logic [STATE_WIDTH-1:0] state_lin;
    logic [STATE_WIDTH-1:0] lin_in;
    logic [LEN_WIDTH-1:0]   rate_bytes;
    logic [LEN_WIDTH-1:0]   total;
    logic [LEN_WIDTH-1:0]   sent;
    logic [LEN_WIDTH-1:0]   offset;
    logic [LEN_WIDTH-1:0]   n_reg;
    logic [LEN_WIDTH-1:0]   win_off;
    logic [LEN_WIDTH-1:0]   win_sent;
    logic [LEN_WIDTH-1:0]   n_bytes;
    logic [OUT_DWIDTH-1:0]  win_data;
    logic [OUT_DWIDTH/8-1:0] win_keep;
    keccak_mode_e           mode_in;
    logic                   hs;

    assign mode_in = keccak_mode_e'(keccak_mode_i);
    assign busy_o  = (state != IDLE);
    assign hs      = m_axis_tvalid_o && m_axis_tready_i;

    always_comb begin
        lin_in = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                lin_in[64*(x+5*y) +: 64] = state_array_i[x][y];
            end
        end
    end

    // The next beat is sized from the counters as they stand after any handshake this cycle,
    // so back-to-back beats need no bubble.
    always_comb begin
        win_off  = offset + (hs ? n_reg : '0);
        win_sent = sent + (hs ? n_reg : '0);
        n_bytes  = KB;
        if ((rate_bytes - win_off) < n_bytes) n_bytes = rate_bytes - win_off;
        if ((total - win_sent) < n_bytes)     n_bytes = total - win_sent;
    end

    squeeze_window #(
        .OUT_DWIDTH (OUT_DWIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_window (
        .state_lin (state_lin),
        .offset    (win_off),
        .n_bytes   (n_bytes),
        .data      (win_data),
        .keep      (win_keep)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            state_lin       <= '0;
            rate_bytes      <= '0;
            total           <= '0;
            sent            <= '0;
            offset          <= '0;
            n_reg           <= '0;
            perm_req_o      <= 1'b0;
            m_axis_tdata_o  <= '0;
            m_axis_tkeep_o  <= '0;
            m_axis_tlast_o  <= 1'b0;
            m_axis_tvalid_o <= 1'b0;
        end else begin
            perm_req_o <= 1'b0;
`ifdef SQUEEZE_ABORT_EN
            if (abort_i && state != IDLE) begin
                state           <= IDLE;
                m_axis_tvalid_o <= 1'b0;
                m_axis_tlast_o  <= 1'b0;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            rate_bytes <= LEN_WIDTH'(rate_i >> 3);
                            total      <= is_shake(mode_in) ? out_len_i
                                                            : LEN_WIDTH'(digest_bytes(mode_in));
                            sent       <= '0;
                            offset     <= '0;
                            state      <= (is_shake(mode_in) && out_len_i == '0) ? DONE : LOAD;
                        end
                    end
                    LOAD: begin
                        state_lin <= lin_in;
                        offset    <= '0;
                        state     <= EMIT;
                    end
                    EMIT: begin
                        if (!m_axis_tvalid_o || m_axis_tready_i) begin
                            if (m_axis_tvalid_o) begin
                                offset <= win_off;
                                sent   <= win_sent;
                            end
                            // Final beat wins over the rate boundary: no permutation after the last byte.
                            if (m_axis_tvalid_o && m_axis_tlast_o) begin
                                m_axis_tvalid_o <= 1'b0;
                                m_axis_tlast_o  <= 1'b0;
                                state           <= DONE;
                            end else if (m_axis_tvalid_o && win_off == rate_bytes) begin
                                m_axis_tvalid_o <= 1'b0;
                                perm_req_o      <= 1'b1;
                                state           <= PERM_WAIT;
                            end else begin
                                m_axis_tdata_o  <= win_data;
                                m_axis_tkeep_o  <= win_keep;
                                m_axis_tlast_o  <= ((win_sent + n_bytes) == total);
                                m_axis_tvalid_o <= 1'b1;
                                n_reg           <= n_bytes;
                            end
                        end
                    end
                    PERM_WAIT: begin
                        if (perm_done_i) state <= LOAD;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
